// File: rtl/rr_arbiter4_v_pkg.sv
// Shared definitions for the four-client round-robin arbiter:
// state encoding, default parameters and the search-order picker.
package rr_arbiter4_v_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam int N_REQ        = 4;
    localparam int HOLD_MAX_DEF = 8;
    localparam int CNT_W_DEF    = 4;

    // Result of a round-robin search: whether anyone qualified, and who.
    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Walks last+1, last+2, last+3, last (mod 4) and returns the first
    // asserted request. With excl_owner set, `last` itself is skipped so the
    // current owner can never re-win its own handoff.
    function automatic pick_t rr_pick(input logic [3:0] req,
                                      input logic [1:0] last,
                                      input logic       excl_owner);
        pick_t      p;
        logic [1:0] c;
        p.found = 1'b0;
        p.idx   = 2'd0;
        for (int k = 1; k <= N_REQ; k++) begin
            c = last + 2'(k);
            if (!p.found && req[c] && !(excl_owner && (k == N_REQ))) begin
                p.found = 1'b1;
                p.idx   = c;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter4_v_or4.sv
// Library four-input OR gate, used for request-present detection.
module OR4_v (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    output logic o_f
);

    assign o_f = i_a | i_b | i_c | i_d;

endmodule

// File: rtl/rr_arbiter4_v.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// hold-while-requesting, fair rotation on release and forced rotation
// after HOLD_MAX consecutive cycles when another client is waiting.
// HOLD_MAX must lie in 2..15 and 2**CNT_W must exceed HOLD_MAX.
module rr_arbiter4_v
    import rr_arbiter4_v_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_id,
    output logic       o_valid,
    output logic       o_any_req,
    output logic       o_preempt
);

    // Last count value an owner may reach; the counter saturates here.
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic [3:0]       gnt_q,   gnt_d;
    logic [1:0]       id_q,    id_d;
    logic [1:0]       last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             valid_q, valid_d;
    logic             pre_q,   pre_d;

    pick_t            pick_all;
    pick_t            pick_ex;
    logic             owner_req;

    OR4_v u_any_req (
        .i_a (i_req[0]),
        .i_b (i_req[1]),
        .i_c (i_req[2]),
        .i_d (i_req[3]),
        .o_f (o_any_req)
    );

    // In GRANT, last_q is the current owner, so searching from it gives both
    // the fresh-grant winner and the next winner excluding the owner.
    assign pick_all  = rr_pick(i_req, last_q, 1'b0);
    assign pick_ex   = rr_pick(i_req, last_q, 1'b1);
    assign owner_req = i_req[last_q];

    // Next-state, grant, pointer and hold-counter decisions.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        pre_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_all.found) begin
                    state_d = ST_GRANT;
                    gnt_d   = 4'b0001 << pick_all.idx;
                    id_d    = pick_all.idx;
                    last_d  = pick_all.idx;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (owner_req) begin
                    if (cnt_q != CNT_TOP) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (pick_ex.found) begin
                        // Hold budget spent and someone is waiting: force it.
                        gnt_d  = 4'b0001 << pick_ex.idx;
                        id_d   = pick_ex.idx;
                        last_d = pick_ex.idx;
                        cnt_d  = '0;
                        pre_d  = 1'b1;
                    end
                    // Otherwise nobody waits: keep grant, counter saturated.
                end else if (pick_ex.found) begin
                    // Release with others pending: direct handoff, no bubble.
                    gnt_d  = 4'b0001 << pick_ex.idx;
                    id_d   = pick_ex.idx;
                    last_d = pick_ex.idx;
                    cnt_d  = '0;
                end else begin
                    // Release with nobody pending: idle, pointer remembers owner.
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                    id_d    = 2'd0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                id_d    = 2'd0;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, grant, pointer and counter registers; async active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            id_q    <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            pre_q   <= pre_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_id  = id_q;
    assign o_valid   = valid_q;
    assign o_preempt = pre_q;

endmodule

// File: tb/tb_rr_arbiter4_v.sv
// Self-checking bench for rr_arbiter4_v: directed scenarios plus randomized
// traffic, all compared against a behavioural owner/pointer/hold model.
module tb_rr_arbiter4_v;

    localparam int HOLD_MAX = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [3:0] i_req = 4'b0000;
    logic [3:0] o_gnt;
    logic [1:0] o_gnt_id;
    logic       o_valid;
    logic       o_any_req;
    logic       o_preempt;

    int checks = 0;
    int errors = 0;

    // Model state: owner index (-1 idle), rotation pointer, cycles held - 1.
    int m_owner;
    int m_last;
    int m_cnt;
    bit m_pre;

    rr_arbiter4_v #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req),
        .o_gnt     (o_gnt),
        .o_gnt_id  (o_gnt_id),
        .o_valid   (o_valid),
        .o_any_req (o_any_req),
        .o_preempt (o_preempt)
    );

    always #5 i_clk = ~i_clk;

    // First requester after `last` in rotation order; -1 if none.
    function automatic int search(input logic [3:0] r, input int last, input bit skip_last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (skip_last && k == 4) continue;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [1:0] exp_id();
        return (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_cnt   = 0;
        m_pre   = 1'b0;
    endtask

    // One clock edge of arbitration, stated as the grant policy rules.
    task automatic model_step(input logic [3:0] r);
        int nxt;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            nxt = search(r, m_last, 1'b0);
            if (nxt >= 0) begin m_owner = nxt; m_last = nxt; m_cnt = 0; end
        end else if (r[m_owner]) begin
            if (m_cnt < HOLD_MAX - 1) m_cnt++;
            else begin
                nxt = search(r, m_owner, 1'b1);
                if (nxt >= 0) begin m_owner = nxt; m_last = nxt; m_cnt = 0; m_pre = 1'b1; end
            end
        end else begin
            nxt = search(r, m_owner, 1'b1);
            if (nxt >= 0) begin m_owner = nxt; m_last = nxt; m_cnt = 0; end
            else begin m_owner = -1; m_cnt = 0; end
        end
    endtask

    // Present a request vector for one edge; returns 1 ns after the edge.
    task automatic drive(input logic [3:0] r);
        i_req = r;
        @(posedge i_clk);
        model_step(r);
        #1;
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        i_req   = 4'b0000;
        repeat (2) @(posedge i_clk);
        #1;
        model_reset();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_req   = 4'b1111;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_gnt !== 4'b0000 || o_valid !== 1'b0 || o_gnt_id !== 2'd0 || o_preempt !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b valid=%b id=%0d pre=%b, want 0000/0/0/0",
                     o_gnt, o_valid, o_gnt_id, o_preempt);
        end
        checks++;
        if (o_any_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_any_req: got %b want 1", o_any_req);
        end
        model_reset();
        i_rst_n = 1'b1;
        drive(4'b1111);
        checks++;
        if (o_gnt !== 4'b0001 || o_gnt_id !== 2'd0 || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b id=%0d valid=%b, want 0001/0/1",
                     o_gnt, o_gnt_id, o_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq_exp [5];
        logic [3:0] seq_got [$];
        logic [3:0] r;
        seq_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        drive(4'b1111);
        seq_got.push_back(o_gnt);
        for (int s = 0; s < 12; s++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_cnt == 1) r[m_owner] = 1'b0;
            drive(r);
            checks++;
            if (o_gnt !== exp_gnt() || o_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_step%0d: gnt=%b valid=%b, want %b/1", s, o_gnt, o_valid, exp_gnt());
            end
            if (o_gnt !== seq_got[$]) seq_got.push_back(o_gnt);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= seq_got.size() || seq_got[i] !== seq_exp[i]) begin
                errors++;
                $display("FAIL rr_sequence[%0d]: got %b want %b", i,
                         (i < seq_got.size()) ? seq_got[i] : 4'bxxxx, seq_exp[i]);
            end
        end
    endtask

    task automatic test_forced_rotation();
        int held;
        bit seen;
        held = 0;
        seen = 1'b0;
        apply_reset();
        for (int s = 0; s < 20 && !seen; s++) begin
            drive((s < 2) ? 4'b0010 : 4'b1010);
            if (o_gnt === 4'b0010) held++;
            else if (o_gnt === 4'b1000) seen = 1'b1;
            checks++;
            if (o_gnt !== exp_gnt() || o_preempt !== m_pre) begin
                errors++;
                $display("FAIL force_step%0d: gnt=%b pre=%b, want %b/%b", s, o_gnt, o_preempt, exp_gnt(), m_pre);
            end
        end
        checks++;
        if (!seen || held != HOLD_MAX || o_preempt !== 1'b1) begin
            errors++;
            $display("FAIL force_handoff: seen=%0d held=%0d pre=%b, want 1/%0d/1", seen, held, o_preempt, HOLD_MAX);
        end
        drive(4'b1010);
        checks++;
        if (o_gnt !== 4'b1000 || o_preempt !== 1'b0) begin
            errors++;
            $display("FAIL force_pulse_width: gnt=%b pre=%b, want 1000/0", o_gnt, o_preempt);
        end
    endtask

    task automatic test_saturation();
        int bad;
        bad = 0;
        apply_reset();
        for (int s = 0; s < 20; s++) begin
            drive(4'b0100);
            if (o_gnt !== 4'b0100 || o_preempt !== 1'b0 || o_gnt_id !== 2'd2) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL saturation: %0d bad cycles, want 0 (gnt=%b pre=%b)", bad, o_gnt, o_preempt);
        end
    endtask

    task automatic test_idle_pointer();
        apply_reset();
        drive(4'b0100);
        drive(4'b0000);
        checks++;
        if (o_gnt !== 4'b0000 || o_valid !== 1'b0 || o_gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL release_idle: gnt=%b valid=%b id=%0d, want 0000/0/0", o_gnt, o_valid, o_gnt_id);
        end
        drive(4'b0101);
        checks++;
        if (o_gnt !== 4'b0001 || o_gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL pointer_memory: gnt=%b id=%0d, want 0001/0", o_gnt, o_gnt_id);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(4'b0010);
        drive(4'b0010);
        checks++;
        if (o_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL async_pre: gnt=%b want 0010", o_gnt);
        end
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_gnt !== 4'b0000 || o_valid !== 1'b0 || o_gnt_id !== 2'd0 || o_any_req !== 1'b1) begin
            errors++;
            $display("FAIL async_clear: gnt=%b valid=%b id=%0d any=%b, want 0000/0/0/1",
                     o_gnt, o_valid, o_gnt_id, o_any_req);
        end
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(4'b0010);
        checks++;
        if (o_gnt !== 4'b0010 || o_gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL async_regrant: gnt=%b id=%0d, want 0010/1", o_gnt, o_gnt_id);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        int bad;
        bad = 0;
        apply_reset();
        r = 4'b0000;
        for (int s = 0; s < 400; s++) begin
            // Mostly sticky requests so long holds and forced rotations occur.
            if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
            drive(r);
            checks++;
            if (o_gnt !== exp_gnt() || o_gnt_id !== exp_id() || o_valid !== (m_owner >= 0) ||
                o_preempt !== m_pre || o_any_req !== (|r) || $countones(o_gnt) > 1) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_step%0d req=%b: gnt=%b id=%0d v=%b pre=%b any=%b, want %b/%0d/%0b/%b/%b",
                             s, r, o_gnt, o_gnt_id, o_valid, o_preempt, o_any_req,
                             exp_gnt(), exp_id(), (m_owner >= 0), m_pre, |r);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_forced_rotation();
        test_saturation();
        test_idle_pointer();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4_v.md
# rr_arbiter4_v

Four-requester round-robin arbiter that shares one datapath resource (e.g. an ALU/adder/mux slice of the combinational datapath) between up to four clients. It registers a one-hot grant, holds it while the owner keeps requesting, rotates fairly on release, and forcibly rotates after a bounded hold time when others are waiting. Its request-present detection is the four-input OR already in the component library.

## Interface
- HOLD_MAX, 8: maximum consecutive grant cycles for one owner while another requester waits; legal range 2..15.
- CNT_W, 4: width of the hold counter; must satisfy 2**CNT_W > HOLD_MAX.

- i_clk  input  1  rising-edge clock; single clock domain.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_req  input  4  request per client, bit k = client k; level-sensitive.
- o_gnt  output  4  registered one-hot grant; all-zero when idle.
- o_gnt_id  output  2  binary index of current owner; 0 when idle.
- o_valid  output  1  registered; 1 when any grant is active (OR of o_gnt).
- o_any_req  output  1  combinational OR of i_req[0..3].
- o_preempt  output  1  registered one-cycle pulse in the first cycle of a grant created by forced rotation.

## Operation
- States: IDLE (no owner) and GRANT (one owner).
- Rotation pointer `last` (2 bits) holds the most recent owner; reset value 3, so first search starts at client 0.
- Search order from `last`: last+1, last+2, last+3, last (mod 4). The first asserted request in that order wins.
- IDLE -> GRANT: any i_req set; winner by search order; hold counter cleared to 0.
- GRANT, owner's i_req high, count < HOLD_MAX-1: stay, count increments.
- GRANT, owner's i_req high, count == HOLD_MAX-1, another request pending: forced handoff to the next winner excluding the owner; o_preempt pulses; count = 0; `last` = new owner.
- GRANT, owner's i_req high, count == HOLD_MAX-1, no other request: keep grant; count saturates at HOLD_MAX-1.
- GRANT, owner's i_req low, other requests pending: direct handoff to the next winner with no idle bubble; count = 0.
- GRANT, owner's i_req low, no requests: -> IDLE; `last` keeps the released owner.
- Counter never wraps. Width rules: indices mod 4, counter CNT_W bits unsigned.
- Reset (async, any time, including mid-grant): state IDLE, o_gnt = 0000, o_gnt_id = 0, o_valid = 0, o_preempt = 0, count = 0, `last` = 3. o_any_req follows i_req even during reset.

## Timing
- Latency: request sampled at edge n produces o_gnt at edge n+1 (1 cycle).
- Release: owner drops i_req before edge n; the new grant (or 0000) is visible after edge n. The old grant is never held past that edge.
- Handoff is atomic. o_gnt is never multi-hot, and there is never a cycle with both the old and the new owner.
- Simultaneous release and forced-rotation condition: treated as a release (no o_preempt).
- Requests that rise and fall between edges are not seen.
- A client must hold i_req until it sees its grant bit. Dropping i_req earlier may still earn a one-cycle grant, which the client ignores.

## Structure
- Shared package/header: state encodings (ST_IDLE=0, ST_GRANT=1), the default HOLD_MAX, and a search-order function/macro returning the winner index from (req, last, exclude_owner).
- Sub-module: instantiate the existing OR4_v (ports i_a..i_d, o_f) for o_any_req. Everything else is flat: next-state/winner logic, state/grant/pointer/counter registers.

## Test plan
- Reset: hold i_rst_n=0 with i_req=1111 -> o_gnt=0000, o_valid=0, o_any_req=1. Release reset -> next edge o_gnt=0001, o_gnt_id=0.
- Round-robin: i_req=1111, each owner drops its request for one cycle after 2 cycles, then re-raises it -> grant sequence 0001, 0010, 0100, 1000, 0001, with no idle cycles.
- Forced rotation, HOLD_MAX=8: client 1 holds req; client 3 raises req at cycle 2 -> client 1 is granted exactly 8 cycles, then o_gnt=1000 with o_preempt=1 for one cycle.
- Saturation: single requester 0100 held 20 cycles -> o_gnt=0100 throughout, o_preempt never asserted.
- Release to idle and pointer memory: grant client 2, drop all requests -> o_gnt=0000 next edge. Then i_req=0101 -> client 0 wins (search starts at 3, wraps to 0).
- Async reset mid-grant: assert i_rst_n low between edges while o_gnt=0010 -> outputs clear immediately without a clock edge. After release with i_req=0010 -> grant returns to 0010 one edge later.
